// File: rtl/arbitrated_fifo_pkg.sv
// Shared constants for the two-producer arbitrated FIFO.
// Config macro: ARBITRATED_FIFO_RR_EN (round-robin arbitration when defined).
package arbitrated_fifo_pkg;
  localparam logic PROD_A   = 1'b0;
  localparam logic PROD_B   = 1'b1;
  // B marked as last winner so A takes the first contention after reset
  localparam logic LAST_RST = PROD_B;
endpackage

// File: rtl/rr_arbiter2.sv
// Two-way write-slot arbiter; owns the last-granted flag.
// Config macro: ARBITRATED_FIFO_RR_EN selects round-robin, otherwise A has fixed priority.
module rr_arbiter2
  import arbitrated_fifo_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic req_a,
  input  logic req_b,
  output logic gnt_a,
  output logic gnt_b
);

  logic en;
  assign en = enable & rst;  // nothing is honoured while reset is held

`ifdef ARBITRATED_FIFO_RR_EN
  logic last;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)              last <= LAST_RST;
    else if (gnt_a)        last <= PROD_A;
    else if (gnt_b)        last <= PROD_B;
  end

  always_comb begin
    gnt_a = 1'b0;
    gnt_b = 1'b0;
    if (en) begin
      if (req_a && req_b) begin
        gnt_a = (last == PROD_B);
        gnt_b = (last == PROD_A);
      end else begin
        gnt_a = req_a;
        gnt_b = req_b;
      end
    end
  end
`else
  logic unused_clk;
  assign unused_clk = clk;

  always_comb begin
    gnt_a = 1'b0;
    gnt_b = 1'b0;
    if (en) begin
      gnt_a = req_a;
      gnt_b = req_b & ~req_a;
    end
  end
`endif

endmodule

// File: rtl/arbitrated_fifo.sv
// Two-producer, one-consumer synchronous FIFO with valid/ready output.
// Config macro: ARBITRATED_FIFO_RR_EN (passed through to rr_arbiter2).
module arbitrated_fifo
  import arbitrated_fifo_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_a,
  input  logic [WIDTH-1:0] data_a,
  output logic             gnt_a,
  input  logic             req_b,
  input  logic [WIDTH-1:0] data_b,
  output logic             gnt_b,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wp, rp;
  logic [CW-1:0]    cnt;
  logic             push, pop;
  logic [WIDTH-1:0] wdata;

  assign full      = (cnt == CW'(DEPTH));
  assign empty     = (cnt == '0);
  assign out_valid = ~empty;
  assign out_data  = mem[rp];
  assign count     = cnt;

  // Full blocks writes even when a pop would free a slot this cycle
  rr_arbiter2 u_arb (
    .clk    (clk),
    .rst    (rst),
    .enable (~full),
    .req_a  (req_a),
    .req_b  (req_b),
    .gnt_a  (gnt_a),
    .gnt_b  (gnt_b)
  );

  assign push  = gnt_a | gnt_b;
  assign pop   = out_valid & out_ready;
  assign wdata = gnt_b ? data_b : data_a;

  always_ff @(posedge clk) begin
    if (push) mem[wp] <= wdata;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (push) wp <= wp + AW'(1);
      if (pop)  rp <= rp + AW'(1);
      case ({push, pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: doc/arbitrated_fifo.md
# arbitrated_fifo

- Two-producer, one-consumer synchronous FIFO.
- Arbitrates between producers A and B for a single write slot per cycle and stores accepted words in DEPTH entries.
- Presents the head word to the downstream register stage through a valid/ready handshake.
- Sits directly upstream of the enable-gated register stage: `out_valid && out_ready` drives that stage's enable, and `out_data` drives its D input.

## Interface
Parameters:
- WIDTH, 8, data word width in bits (≥1)
- DEPTH, 4, number of entries; power of two, ≥2
- CW, $clog2(DEPTH)+1, occupancy counter width (derived; not overridden)

Ports:
- clk  input  1  sole clock; all state updates on posedge
- rst  input  1  asynchronous, active-low reset; asserting low clears all state immediately, deassertion is synchronous to clk externally
- req_a  input  1  producer A has a word to write
- data_a  input  WIDTH  producer A word
- gnt_a  output  1  A's word is written at this clock edge (combinational)
- req_b  input  1  producer B has a word to write
- data_b  input  WIDTH  producer B word
- gnt_b  output  1  B's word is written at this clock edge (combinational)
- out_valid  output  1  FIFO non-empty; `out_data` is the head
- out_data  output  WIDTH  head entry
- out_ready  input  1  consumer accepts head at this clock edge
- count  output  CW  current occupancy, 0..DEPTH
- full  output  1  count == DEPTH
- empty  output  1  count == 0

## Operation
- State:
  - storage array `mem[DEPTH]`
  - write pointer `wp` and read pointer `rp`, each log2(DEPTH) bits; they wrap naturally modulo DEPTH
  - `count` (CW bits)
  - last-granted flag `last` (0 = A, 1 = B)
- Grant, all combinational, at most one grant per cycle:
  - If full: `gnt_a = gnt_b = 0` regardless of `out_ready`. No write when full, even with a simultaneous pop.
  - Else if only one request is high, that producer is granted.
  - Else if both are high, the producer not equal to `last` is granted (round-robin).
- Write (`push = gnt_a | gnt_b`): at the edge, `mem[wp]` ← granted data, `wp` ← `wp+1`, and `last` ← granted producer. `last` is unchanged when there is no grant.
- Read (`pop = out_valid & out_ready`): at the edge, `rp` ← `rp+1`. `out_ready` while empty is ignored.
- Count: +1 on push only, −1 on pop only, unchanged on both or neither.
- Flags: `out_valid = !empty`; `out_data = mem[rp]`. `out_data` is undefined-but-stable when empty; verification must not check it then.
- Simultaneous push and pop when not full and not empty: both occur, count holds, ordering is preserved.
- Push when empty: the word is visible on `out_data` the next cycle. There is no bypass, so a word cannot be popped in the cycle it is pushed.
- Reset: `wp = rp = 0`, `count = 0`, `last = 1` (A wins the first contention). Outputs become `out_valid = 0`, `empty = 1`, `full = 0`, `gnt_a = gnt_b = 0` (no requests honoured while `rst` is low). Storage contents are not reset.
- Reset mid-operation discards all stored words; no partial state survives.

## Timing
- Grants are combinational from `req_*`, `full` and `last`. Requests must be stable before the edge.
- Producer handshake: a word is consumed exactly at an edge where `gnt_x = 1`. A producer holds its request and data until granted.
- Write-to-read latency is 1 cycle: a word written at edge N is valid after edge N.
- Throughput is 1 write and 1 read per cycle.
- Worst-case wait for a continuously requesting producer under contention is 1 cycle.

## Configuration
- Macro: ARBITRATED_FIFO_RR_EN.
- Defined: round-robin arbitration using `last`, as described above.
- Undefined: fixed priority, A always wins contention. `last` is not implemented, and B is granted only when `req_a = 0`.
- All other behaviour is identical in both builds.

## Structure
- Package `arbitrated_fifo_pkg`:
  - producer-id constants PROD_A = 1'b0 and PROD_B = 1'b1
  - reset value of `last`
- Sub-module `rr_arbiter2`:
  - inputs: req_a, req_b, enable (= !full), clk, rst
  - outputs: gnt_a, gnt_b
  - owns the `last` register and the macro-dependent policy
- Top level holds storage, pointers and count.

## Test plan
- Reset, then A writes 0x11, 0x22, 0x33; hold out_ready=1 → out_data sequence 0x11, 0x22, 0x33, each one cycle after its write; count returns to 0, empty=1.
- Both producers request continuously with out_ready=0, DEPTH=4, RR build → grants A, B, A, B; then full=1, count=4, gnt_a=gnt_b=0; contents pop in that order.
- Same stimulus, fixed-priority build → four A grants, B never granted until req_a drops.
- Full FIFO with req_a=1 and out_ready=1 → pop occurs, no grant that cycle, count 4→3; next cycle A is granted, count stays 3 if popping continues.
- Fill and drain 3×DEPTH words with random simultaneous push/pop → pointers wrap; output order matches an arbitration-order reference model; count never exceeds DEPTH.
- Assert rst low mid-stream with count=2 → immediately count=0, empty=1, out_valid=0, grants 0; after release, first contention is won by A.
